// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues one instruction-memory request at a
// time, and buffers PC-tagged instructions for decode in a small circular queue.
module fetch_queue #(
  parameter int PC_WIDTH   = 9,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready
);

  // state | meaning
  // IDLE  | no request outstanding (queue full, or just out of reset)
  // REQ   | request outstanding, response will be enqueued
  // DROP  | request outstanding, response discarded after a redirect
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]       DEPTH_C  = CW'(DEPTH);
  localparam logic [PC_WIDTH-1:0] RST_PC_C = PC_WIDTH'(RESET_PC);

  state_t                r_state, w_state_next;
  logic [PC_WIDTH-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [PC_WIDTH-1:0]   r_pend_pc, w_pend_pc_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic [AW-1:0]         r_head, r_tail;
  logic [INST_WIDTH-1:0] r_q_inst [DEPTH];
  logic [PC_WIDTH-1:0]   r_q_pc   [DEPTH];

  logic w_enq, w_pop, w_flush;

  assign w_flush = redirect;
  assign w_enq   = (r_state == S_REQ) && imem_ack && !redirect;
  assign w_pop   = inst_ready && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_flush)
      w_count_next = '0;
    else
      w_count_next = r_count + CW'(w_enq) - CW'(w_pop);
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pend_pc_next  = r_pend_pc;
    case (r_state)
      S_IDLE: begin
        if (redirect) begin
          w_fetch_pc_next = redirect_pc;
          w_state_next    = S_REQ;
        end else if (r_count < DEPTH_C) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (imem_ack && redirect) begin
          w_fetch_pc_next = redirect_pc;
          w_state_next    = S_REQ;
        end else if (imem_ack) begin
          w_fetch_pc_next = r_fetch_pc + PC_WIDTH'(1);
          w_state_next    = (w_count_next < DEPTH_C) ? S_REQ : S_IDLE;
        end else if (redirect) begin
          // address must hold until the ack, so park the target
          w_pend_pc_next = redirect_pc;
          w_state_next   = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect)
          w_pend_pc_next = redirect_pc;
        if (imem_ack) begin
          w_fetch_pc_next = redirect ? redirect_pc : r_pend_pc;
          w_state_next    = S_REQ;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RST_PC_C;
      r_pend_pc  <= RST_PC_C;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pend_pc  <= w_pend_pc_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      r_count <= w_count_next;
      if (w_flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq) begin
          r_q_inst[r_tail] <= imem_rdata;
          r_q_pc[r_tail]   <= r_fetch_pc;
          r_tail           <= r_tail + AW'(1);
        end
        if (w_pop)
          r_head <= r_head + AW'(1);
      end
    end
  end

  assign imem_req   = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem_addr  = r_fetch_pc;
  assign inst_valid = (r_count != '0);
  assign inst       = r_q_inst[r_head];
  assign inst_pc    = r_q_pc[r_head];

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the PC datapath. Owns the fetch PC and issues word-address requests to instruction memory over a req/ack handshake.
- Buffers returned instructions, each tagged with its PC, in a small FIFO. The FIFO is drained by decode over a valid/ready handshake.
- Branch/jump redirects flush the queue and restart fetch at the target. A response still in flight when a redirect arrives is discarded.

Parameters:
PC_WIDTH, 9, width of word address / PC
INST_WIDTH, 32, instruction width
DEPTH, 2, queue entries; power of two, >= 2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset asserted
redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  PC_WIDTH  redirect target, sampled when redirect=1
imem_req  out  1  request to instruction memory
imem_addr  out  PC_WIDTH  request address; stable while imem_req=1 until imem_ack
imem_ack  in  1  memory completes request this cycle; imem_rdata valid this cycle
imem_rdata  in  INST_WIDTH  fetched instruction
inst_valid  out  1  queue head valid
inst  out  INST_WIDTH  head instruction
inst_pc  out  PC_WIDTH  PC of head instruction
inst_ready  in  1  decode consumes head when inst_valid=1 and inst_ready=1

Behaviour:
- All state is registered; reset acts asynchronously (reset=0) and releases synchronously on the next clock edge.
- During reset: state=IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
- First cycle after reset release: state=REQ, imem_req=1, imem_addr=RESET_PC.
- imem_req=1 in states REQ and DROP. imem_addr=fetch_pc at all times.
- Exactly one request is outstanding at a time.
- State IDLE (no request):
  - Goes to REQ when count<DEPTH, or on a redirect.
- State REQ (request outstanding, response kept):
  - imem_ack=1, no redirect: enqueue {imem_rdata, fetch_pc}; fetch_pc <= fetch_pc+1 modulo 2^PC_WIDTH (511 -> 0).
  - After the ack, the next state is REQ if count_next<DEPTH, else IDLE.
  - imem_ack=1 and redirect=1 in the same cycle: drop the data, flush, fetch_pc <= redirect_pc, next state REQ.
  - imem_ack=0 and redirect=1: imem_addr must not change. Latch the target in pend_pc, flush, next state DROP.
- State DROP (request outstanding, response discarded):
  - A further redirect overwrites pend_pc.
  - On imem_ack: discard the data, fetch_pc <= pend_pc, or redirect_pc if redirect=1 in that same cycle; next state REQ.
- Queue:
  - Circular buffer of DEPTH entries with head/tail pointers and count (0..DEPTH).
  - inst_valid = (count != 0); inst and inst_pc are driven combinationally from the head entry.
  - Pop and enqueue in the same cycle: count unchanged.
  - A request is started only when count<DEPTH, so an enqueue never overflows.
  - Pop with count=0 is ignored.
- Flush (any redirect): count <= 0 and pointers reset. It overrides any pop or enqueue in the same cycle, so inst_valid=0 in the following cycle.
- Latency:
  - Redirect in IDLE: imem_req/addr=target on the next cycle.
  - With a same-cycle ack, inst_valid=1 and inst_pc=target one cycle after that; minimum 2 cycles from redirect to instruction.
  - Steady state with an ack every cycle: one instruction per cycle.
- Reset asserted mid-request: the request is abandoned. Memory must tolerate imem_req dropping without an ack.

Test Plan:
- Reset, then ack every request with rdata=0x1000_0000+addr, inst_ready=1 -> imem_addr 0,1,2,...; inst_pc=0 with inst=0x1000_0000 on the 3rd cycle after release; one instruction per cycle thereafter.
- inst_ready=0 with immediate acks -> after 2 enqueues (pc 0,1) imem_req=0, state IDLE, inst_pc=0 held. Raise inst_ready for 1 cycle -> head becomes pc 1, imem_req=1 with addr=2.
- Redirect to 0x05A in IDLE with queue full -> inst_valid=0 on the next cycle, imem_addr=0x05A, first new inst_pc=0x05A, then 0x05B.
- Request at addr 3 held with ack=0 for 3 cycles, redirect to 0x100 in cycle 1 -> imem_addr stays 3 until ack; acked data never appears at inst; the next request has addr 0x100.
- Preload fetch_pc=0x1FF via redirect 0x1FF -> consecutive inst_pc 0x1FF, 0x000, 0x001.
- Assert reset during DROP with the queue holding 2 entries -> imem_req=0 and inst_valid=0 immediately; after release, fetch restarts at RESET_PC with no stale data.
